systolic_feed_ctrl: RTL and testbench



---
 rtl/systolic_feed_ctrl_if.sv | 30 +++
 rtl/systolic_feed_ctrl.sv | 132 +++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feed_ctrl_if.sv
// Handshake and control bundle between dispatch, the matrix bus and the
// systolic feed sequencer.
interface systolic_feed_ctrl_if #(
  parameter int MAC_WIDTH = 16,
  parameter int KW        = 16
);
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 stall;
  logic                 mat_req;
  logic                 mat_valid;
  logic                 load_en;
  logic [MAC_WIDTH-1:0] row_en;
  logic                 acc_clear;
  logic                 drain_shift;
  logic                 busy;
  logic                 done;

  // Environment side: dispatch, matrix bus and downstream back-pressure.
  modport master (
    output start, k_len, stall, mat_valid,
    input  mat_req, load_en, row_en, acc_clear, drain_shift, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, k_len, stall, mat_valid,
    output mat_req, load_en, row_en, acc_clear, drain_shift, busy, done
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Systolic input skew sequencer: fetch one tile, pulse the skew-buffer write,
// drive the diagonal row-enable pattern into the MAC array, drain, report done.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; k_len latched on accept
//   S_REQ   | mat_req high, waiting for mat_valid
//   S_LOAD  | one-cycle load_en into the skew FIFOs
//   S_FEED  | t = 0 .. k_len+MAC_WIDTH-2, pyramidal row_en
//   S_DRAIN | MAC_WIDTH non-stalled drain_shift cycles
//   S_DONE  | one-cycle done pulse
module systolic_feed_ctrl #(
  parameter int MAC_WIDTH = 16,
  parameter int KW        = 16,
  parameter int CW        = 17
) (
  input  logic                 clock,
  input  logic                 reset,
  systolic_feed_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] MW_C = CW'(MAC_WIDTH);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [KW-1:0]         klen_q, klen_d;
  logic                  mat_req_q, mat_req_d;

  logic [CW-1:0]         klen_ext;
  logic [CW-1:0]         feed_last;
  logic [CW-1:0]         drain_last;
  logic                  feed_act;
  logic [MAC_WIDTH-1:0]  row_en_w;

  // FEED only runs with k_len >= 1, so k_len+MAC_WIDTH-2 never underflows there.
  assign klen_ext   = CW'(klen_q);
  assign feed_last  = klen_ext + MW_C - CW'(2);
  assign drain_last = MW_C - CW'(1);

  // State, counter, latched k_len and the registered request.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      klen_q    <= '0;
      mat_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      klen_q    <= klen_d;
      mat_req_q <= mat_req_d;
    end
  end

  // Next-state and counter sequencing; stall freezes FEED/DRAIN progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          klen_d  = bus.k_len;
          cnt_d   = '0;
          state_d = (bus.k_len == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mat_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (!bus.stall) begin
          if (cnt_q == feed_last) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!bus.stall) begin
          if (cnt_q == drain_last) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    mat_req_d = (state_d == S_REQ);
  end

  assign feed_act = (state_q == S_FEED) && !bus.stall;

  // Diagonal enable: row i active while i <= t < i+k_len (no subtraction).
  always_comb begin
    row_en_w = '0;
    for (int i = 0; i < MAC_WIDTH; i++) begin
      row_en_w[i] = feed_act && (CW'(i) <= cnt_q) && (cnt_q < (CW'(i) + klen_ext));
    end
  end

  assign bus.mat_req     = mat_req_q;
  assign bus.load_en     = (state_q == S_LOAD);
  assign bus.row_en      = row_en_w;
  assign bus.acc_clear   = feed_act && (cnt_q == '0);
  assign bus.drain_shift = (state_q == S_DRAIN) && !bus.stall;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: hand-written vector table, directed corner
// sequences and randomized tiles scored against a schedule-level model.
module tb_systolic_feed_ctrl;

  localparam int MW = 4;
  localparam int KW = 16;

  typedef struct {
    logic          rst_n;
    logic          start;
    logic [KW-1:0] k;
    logic          mv;
    logic          st;
    logic          req;
    logic          load;
    logic [MW-1:0] row;
    logic          clr;
    logic          drn;
    logic          busy;
    logic          done;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  vec_t q[$];
  vec_t tbl[17];

  systolic_feed_ctrl_if #(.MAC_WIDTH(MW), .KW(KW)) bus ();

  systolic_feed_ctrl #(.MAC_WIDTH(MW), .KW(KW), .CW(17)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mkv(logic rst_n, logic start, logic [KW-1:0] k, logic mv, logic st,
                               logic req, logic load, logic [MW-1:0] row, logic clr,
                               logic drn, logic busy, logic done);
    vec_t v;
    v.rst_n = rst_n; v.start = start; v.k = k; v.mv = mv; v.st = st;
    v.req = req; v.load = load; v.row = row; v.clr = clr; v.drn = drn;
    v.busy = busy; v.done = done;
    return v;
  endfunction

  // Diagonal occupancy at feed step t: row i carries element t-i when 0 <= t-i < k.
  function automatic logic [MW-1:0] diag(int t, int k);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < MW; i++) begin
      int e;
      e = t - i;
      if (e >= 0 && e < k) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic rbit(bit rnd);
    return rnd ? logic'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic logic [KW-1:0] rk(bit rnd);
    return rnd ? KW'($urandom_range(0, 65535)) : '0;
  endfunction

  // Expected cycle-by-cycle trace of one tile, starting from an idle DUT.
  // d: REQ cycles before mat_valid; fs_pos/fs_len: forced stall run at feed step fs_pos.
  task automatic gen_txn(input int k, input int d, input bit rnd, input int fs_pos, input int fs_len);
    int t;
    int n;
    int inj;
    logic s;
    q.push_back(mkv(1, 1, KW'(k), rbit(rnd), rbit(rnd), 0, 0, '0, 0, 0, 0, 0));
    if (k == 0) begin
      q.push_back(mkv(1, rbit(rnd), rk(rnd), rbit(rnd), rbit(rnd), 0, 0, '0, 0, 0, 1, 1));
      return;
    end
    for (int j = 0; j <= d; j++)
      q.push_back(mkv(1, rbit(rnd), rk(rnd), (j == d), rbit(rnd), 1, 0, '0, 0, 0, 1, 0));
    q.push_back(mkv(1, rbit(rnd), rk(rnd), rbit(rnd), rbit(rnd), 0, 1, '0, 0, 0, 1, 0));
    t = 0;
    inj = fs_len;
    while (t <= k + MW - 2) begin
      if (t == fs_pos && inj > 0) begin
        q.push_back(mkv(1, rbit(rnd), rk(rnd), rbit(rnd), 1, 0, 0, '0, 0, 0, 1, 0));
        inj--;
      end else begin
        s = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (s) begin
          q.push_back(mkv(1, rbit(rnd), rk(rnd), rbit(rnd), 1, 0, 0, '0, 0, 0, 1, 0));
        end else begin
          q.push_back(mkv(1, rbit(rnd), rk(rnd), rbit(rnd), 0, 0, 0, diag(t, k), (t == 0), 0, 1, 0));
          t++;
        end
      end
    end
    n = 0;
    while (n < MW) begin
      s = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      q.push_back(mkv(1, rbit(rnd), rk(rnd), rbit(rnd), s, 0, 0, '0, 0, !s, 1, 0));
      if (!s) n++;
    end
    q.push_back(mkv(1, rbit(rnd), rk(rnd), rbit(rnd), rbit(rnd), 0, 0, '0, 0, 0, 1, 1));
  endtask

  task automatic idle_gap(input int n, input bit rnd);
    for (int j = 0; j < n; j++)
      q.push_back(mkv(1, 0, rk(rnd), rbit(rnd), rbit(rnd), 0, 0, '0, 0, 0, 0, 0));
  endtask

  task automatic trunc_q(input int n);
    vec_t dummy;
    while (q.size() > n) dummy = q.pop_back();
  endtask

  // Drive one cycle's inputs after the edge, compare outputs mid-cycle.
  task automatic apply_vec(input vec_t v, input string tag);
    logic [MW+5:0] got, exp;
    @(posedge clock);
    #1;
    reset         = v.rst_n;
    bus.start     = v.start;
    bus.k_len     = v.k;
    bus.mat_valid = v.mv;
    bus.stall     = v.st;
    @(negedge clock);
    got = {bus.mat_req, bus.load_en, bus.row_en, bus.acc_clear, bus.drain_shift, bus.busy, bus.done};
    exp = {v.req, v.load, v.row, v.clr, v.drn, v.busy, v.done};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got req=%b load=%b row=%b clr=%b drn=%b busy=%b done=%b exp req=%b load=%b row=%b clr=%b drn=%b busy=%b done=%b",
               tag, cyc, bus.mat_req, bus.load_en, bus.row_en, bus.acc_clear, bus.drain_shift,
               bus.busy, bus.done, v.req, v.load, v.row, v.clr, v.drn, v.busy, v.done);
    end
    cyc++;
  endtask

  task automatic apply_q(input string tag);
    while (q.size() > 0) apply_vec(q.pop_front(), tag);
  endtask

  initial begin
    bus.start = 1'b0; bus.k_len = '0; bus.mat_valid = 1'b0; bus.stall = 1'b0;

    // Reset state, then the basic k_len=3 tile with mat_valid in the first REQ cycle.
    tbl[0]  = mkv(0, 1, 16'd3, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 0, 16'd0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    tbl[2]  = mkv(1, 1, 16'd3, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    tbl[3]  = mkv(1, 0, 16'd0, 1, 0, 1, 0, 4'b0000, 0, 0, 1, 0);
    tbl[4]  = mkv(1, 0, 16'd0, 0, 0, 0, 1, 4'b0000, 0, 0, 1, 0);
    tbl[5]  = mkv(1, 0, 16'd0, 0, 0, 0, 0, 4'b0001, 1, 0, 1, 0);
    tbl[6]  = mkv(1, 0, 16'd0, 0, 0, 0, 0, 4'b0011, 0, 0, 1, 0);
    tbl[7]  = mkv(1, 0, 16'd0, 0, 0, 0, 0, 4'b0111, 0, 0, 1, 0);
    tbl[8]  = mkv(1, 0, 16'd0, 0, 0, 0, 0, 4'b1110, 0, 0, 1, 0);
    tbl[9]  = mkv(1, 0, 16'd0, 0, 0, 0, 0, 4'b1100, 0, 0, 1, 0);
    tbl[10] = mkv(1, 0, 16'd0, 0, 0, 0, 0, 4'b1000, 0, 0, 1, 0);
    tbl[11] = mkv(1, 0, 16'd0, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 0);
    tbl[12] = mkv(1, 0, 16'd0, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 0);
    tbl[13] = mkv(1, 0, 16'd0, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 0);
    tbl[14] = mkv(1, 0, 16'd0, 0, 0, 0, 0, 4'b0000, 0, 1, 1, 0);
    tbl[15] = mkv(1, 0, 16'd0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 1);
    tbl[16] = mkv(1, 0, 16'd0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) apply_vec(tbl[i], "table");

    // Late mat_valid: request held six cycles.
    gen_txn(3, 5, 0, -1, 0);
    idle_gap(1, 0);
    apply_q("late_valid");

    // Two-cycle stall at the third feed step.
    gen_txn(3, 0, 0, 2, 2);
    apply_q("feed_stall");

    // k_len=0 goes straight to done; then a tile with start/k_len/mat_valid noise while busy.
    gen_txn(0, 0, 0, -1, 0);
    gen_txn(3, 1, 1, -1, 0);
    idle_gap(2, 1);
    apply_q("zero_and_noise");

    // Reset during DRAIN, then a k_len=1 tile.
    gen_txn(3, 0, 0, -1, 0);
    trunc_q(11);
    q.push_back(mkv(0, 0, '0, 0, 0, 0, 0, '0, 0, 1, 1, 0));
    q.push_back(mkv(1, 0, '0, 0, 0, 0, 0, '0, 0, 0, 0, 0));
    gen_txn(1, 0, 0, -1, 0);
    apply_q("reset_drain");

    // Reset while a request is pending drops it; later mat_valid is ignored.
    gen_txn(3, 4, 0, -1, 0);
    trunc_q(3);
    q.push_back(mkv(0, 0, '0, 0, 0, 1, 0, '0, 0, 0, 1, 0));
    q.push_back(mkv(1, 0, '0, 1, 0, 0, 0, '0, 0, 0, 0, 0));
    q.push_back(mkv(1, 0, '0, 1, 0, 0, 0, '0, 0, 0, 0, 0));
    apply_q("reset_req");

    // Randomized tiles with random stalls and ignored-input noise.
    for (int n = 0; n < 60; n++) begin
      int k;
      k = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 20));
      gen_txn(k, int'($urandom_range(0, 4)), 1, -1, 0);
      idle_gap(int'($urandom_range(0, 2)), 1);
      apply_q("random");
    end

    // One long tile exercising wider counter values.
    gen_txn(300, 2, 1, -1, 0);
    apply_q("long");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
